// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
//   Multi-cycle control FSM for an RV32I core. Walks the shared datapath
//   through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for every instruction,
//   runs the IMEM/DMEM req/ack handshakes, strobes PC update and register
//   writeback, counts retired instructions and traps on illegal opcodes or
//   memory timeouts. Once in TRAP, only rst_n gets the FSM out again.
//
// Ports
//   clk, rst_n              core clock, async active-low reset
//   hold_i                  freeze before the next fetch (no effect once a
//                           fetch request is outstanding)
//   imem_req/imem_ack/instr_i, ir_we     instruction fetch handshake
//   dmem_req/dmem_ack, mem_read/mem_write data memory handshake
//   alu_zero_i              branch compare result
//   alu_en, alu_src, alu_op ALU control (EXEC only)
//   reg_write, wb_sel       register writeback control
//   pc_we, pc_sel           PC update control
//   retire, instret         retire pulse and retired-instruction count
//   trap, trap_cause        sticky fault flag and its cause
// ---------------------------------------------------------------------------
module multicycle_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold_i,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      instr_i,
    output logic             ir_we,
    input  logic             alu_zero_i,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             mem_read,
    output logic             mem_write,
    output logic             alu_en,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             reg_write,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] CAUSE_ILL  = 2'b01;
    localparam logic [1:0] CAUSE_IMEM = 2'b10;
    localparam logic [1:0] CAUSE_DMEM = 2'b11;

    localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Value of the wait counter during the TIMEOUT-th consecutive ack-less
    // request cycle; missing the ack in that cycle traps.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    logic [2:0]        state_q, state_d;
    logic [6:0]        opcode_q, opcode_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              req_pend_q, req_pend_d;
    logic [1:0]        trap_cause_q, trap_cause_d;
    logic [CNT_W-1:0]  instret_q, instret_d;
    logic              legal;

    always_comb begin
        legal = 1'b0;
        case (opcode_q)
            OP_R, OP_LOAD, OP_IMM, OP_STORE,
            OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        opcode_d     = opcode_q;
        // Counter only survives consecutive ack-less request cycles; any
        // state change (entry to FETCH/MEM included) restarts it at zero.
        wait_cnt_d   = '0;
        req_pend_d   = 1'b0;
        trap_cause_d = trap_cause_q;

        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        alu_en    = 1'b0;
        alu_src   = 1'b0;
        alu_op    = 2'b00;
        reg_write = 1'b0;
        wb_sel    = 2'b00;
        pc_we     = 1'b0;
        pc_sel    = 2'b00;
        retire    = 1'b0;
        trap      = 1'b0;

        case (state_q)
            S_FETCH: begin
                // rst_n gating keeps imem_req low while reset is asserted,
                // since FETCH is also the reset state.
                imem_req = rst_n & (~hold_i | req_pend_q);
                if (imem_req) begin
                    if (imem_ack) begin
                        ir_we    = 1'b1;
                        opcode_d = instr_i[6:0];
                        state_d  = S_DECODE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        trap_cause_d = CAUSE_IMEM;
                        state_d      = S_TRAP;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                        req_pend_d = 1'b1;
                    end
                end
            end

            S_DECODE: begin
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    trap_cause_d = CAUSE_ILL;
                    state_d      = S_TRAP;
                end
            end

            S_EXEC: begin
                alu_en = 1'b1;
                case (opcode_q)
                    OP_R: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    OP_IMM: begin
                        alu_src = 1'b1;
                        alu_op  = 2'b11;
                        state_d = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src = 1'b1;
                        state_d = S_MEM;
                    end
                    OP_AUIPC: begin
                        alu_src = 1'b1;
                        state_d = S_WB;
                    end
                    OP_BRANCH: begin
                        // Branches resolve here: no MEM, no writeback.
                        alu_op  = 2'b01;
                        pc_we   = 1'b1;
                        pc_sel  = alu_zero_i ? 2'b01 : 2'b00;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: state_d = S_WB;   // JAL, LUI
                endcase
            end

            S_MEM: begin
                dmem_req  = 1'b1;
                mem_read  = (opcode_q == OP_LOAD);
                mem_write = (opcode_q == OP_STORE);
                if (dmem_ack) begin
                    if (opcode_q == OP_LOAD) begin
                        state_d = S_WB;
                    end else begin
                        // Store completes this cycle, so the PC update is
                        // not concurrent with an outstanding request.
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    trap_cause_d = CAUSE_DMEM;
                    state_d      = S_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                pc_we     = 1'b1;
                retire    = 1'b1;
                case (opcode_q)
                    OP_LOAD: wb_sel = 2'b01;
                    OP_JAL:  wb_sel = 2'b10;
                    OP_LUI:  wb_sel = 2'b11;
                    default: wb_sel = 2'b00;
                endcase
                pc_sel  = (opcode_q == OP_JAL) ? 2'b10 : 2'b00;
                state_d = S_FETCH;
            end

            S_TRAP: begin
                trap = 1'b1;
            end

            default: state_d = S_FETCH;
        endcase
    end

    assign instret_d  = instret_q + CNT_W'(retire);
    assign instret    = instret_q;
    assign trap_cause = trap_cause_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            opcode_q     <= '0;
            wait_cnt_q   <= '0;
            req_pend_q   <= 1'b0;
            trap_cause_q <= 2'b00;
            instret_q    <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            wait_cnt_q   <= wait_cnt_d;
            req_pend_q   <= req_pend_d;
            trap_cause_q <= trap_cause_d;
            instret_q    <= instret_d;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: inputs are driven 1 ns after the
// rising edge, outputs are compared 2 ns after it.
module tb_multicycle_sequencer;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h00112023;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_LUI  = 32'h00000037;
    localparam logic [31:0] I_ILL  = 32'h0000007F;

    logic        clk, rst_n, hold_i;
    logic        imem_req, imem_ack, ir_we;
    logic [31:0] instr_i;
    logic        alu_zero_i;
    logic        dmem_req, dmem_ack, mem_read, mem_write;
    logic        alu_en, alu_src;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        retire;
    logic [31:0] instret;
    logic        trap;
    logic [1:0]  trap_cause;

    int n_chk = 0;
    int n_err = 0;

    multicycle_sequencer #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .hold_i(hold_i),
        .imem_req(imem_req), .imem_ack(imem_ack), .instr_i(instr_i), .ir_we(ir_we),
        .alu_zero_i(alu_zero_i),
        .dmem_req(dmem_req), .dmem_ack(dmem_ack), .mem_read(mem_read), .mem_write(mem_write),
        .alu_en(alu_en), .alu_src(alu_src), .alu_op(alu_op),
        .reg_write(reg_write), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold_i = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        alu_zero_i = 1'b0;
        #1;
        cyc();
        rst_n = 1'b1;
    endtask

    // One-cycle fetch with immediate ack; returns in the DECODE cycle.
    task automatic fetch(input logic [31:0] ins);
        imem_ack = 1'b1;
        instr_i = ins;
        #1;
        chk("fetch_ir_we", 32'(ir_we), 32'd1);
        cyc();
        imem_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; hold_i = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        instr_i = '0; alu_zero_i = 1'b0;

        // Reset state: FSM sits in FETCH but all outputs stay low.
        #2;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_trap", 32'(trap), 32'd0);
        chk("rst_cause", 32'(trap_cause), 32'd0);
        chk("rst_instret", instret, 32'd0);
        cyc();
        rst_n = 1'b1;

        // 1: ADD, 4 cycles
        fetch(I_ADD);
        #1; chk("add_dec_alu_en", 32'(alu_en), 32'd0); cyc();
        #1; chk("add_alu_en", 32'(alu_en), 32'd1);
        chk("add_alu_op", 32'(alu_op), 32'd2);
        chk("add_alu_src", 32'(alu_src), 32'd0); cyc();
        #1; chk("add_reg_write", 32'(reg_write), 32'd1);
        chk("add_pc_we", 32'(pc_we), 32'd1);
        chk("add_wb_sel", 32'(wb_sel), 32'd0);
        chk("add_pc_sel", 32'(pc_sel), 32'd0);
        chk("add_retire", 32'(retire), 32'd1); cyc();
        #1; chk("add_instret", instret, 32'd1);
        chk("add_next_fetch", 32'(imem_req), 32'd1);

        // 2: LW with dmem_ack on the 4th MEM cycle
        fetch(I_LW);
        #1; chk("lw_dec_reg_write", 32'(reg_write), 32'd0); cyc();
        #1; chk("lw_alu_src", 32'(alu_src), 32'd1);
        chk("lw_alu_op", 32'(alu_op), 32'd0); cyc();
        for (int i = 0; i < 4; i++) begin
            dmem_ack = (i == 3);
            #1;
            chk("lw_dmem_req", 32'(dmem_req), 32'd1);
            chk("lw_mem_read", 32'(mem_read), 32'd1);
            chk("lw_mem_write", 32'(mem_write), 32'd0);
            chk("lw_mem_pc_we", 32'(pc_we), 32'd0);
            cyc();
            dmem_ack = 1'b0;
        end
        #1; chk("lw_wb_sel", 32'(wb_sel), 32'd1);
        chk("lw_reg_write", 32'(reg_write), 32'd1);
        chk("lw_dmem_req_wb", 32'(dmem_req), 32'd0); cyc();
        #1; chk("lw_instret", instret, 32'd2);

        // 3: BEQ taken, then not taken
        fetch(I_BEQ); cyc();
        alu_zero_i = 1'b1;
        #1; chk("beq_t_pc_we", 32'(pc_we), 32'd1);
        chk("beq_t_pc_sel", 32'(pc_sel), 32'd1);
        chk("beq_t_reg_write", 32'(reg_write), 32'd0);
        chk("beq_t_alu_op", 32'(alu_op), 32'd1);
        chk("beq_t_retire", 32'(retire), 32'd1); cyc();
        alu_zero_i = 1'b0;
        #1; chk("beq_t_fetch", 32'(imem_req), 32'd1);
        fetch(I_BEQ); cyc();
        #1; chk("beq_n_pc_we", 32'(pc_we), 32'd1);
        chk("beq_n_pc_sel", 32'(pc_sel), 32'd0); cyc();
        #1; chk("beq_instret", instret, 32'd4);

        // 6a: JAL and LUI writeback selects
        fetch(I_JAL); cyc(); cyc();
        #1; chk("jal_wb_sel", 32'(wb_sel), 32'd2);
        chk("jal_pc_sel", 32'(pc_sel), 32'd2);
        chk("jal_reg_write", 32'(reg_write), 32'd1); cyc();
        fetch(I_LUI); cyc(); cyc();
        #1; chk("lui_wb_sel", 32'(wb_sel), 32'd3);
        chk("lui_pc_sel", 32'(pc_sel), 32'd0); cyc();
        #1; chk("lui_instret", instret, 32'd6);

        // 6b: async reset in the middle of a store's MEM phase
        fetch(I_SW); cyc(); cyc();
        #1; chk("sw_dmem_req", 32'(dmem_req), 32'd1);
        chk("sw_mem_write", 32'(mem_write), 32'd1); cyc();
        rst_n = 1'b0;
        #1; chk("sw_rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("sw_rst_mem_write", 32'(mem_write), 32'd0);
        chk("sw_rst_pc_we", 32'(pc_we), 32'd0);
        chk("sw_rst_retire", 32'(retire), 32'd0);
        chk("sw_rst_instret", instret, 32'd0);
        cyc();
        rst_n = 1'b1;

        // 4: illegal opcode traps, acks ignored, reset clears
        fetch(I_ILL);
        #1; chk("ill_dec_trap", 32'(trap), 32'd0); cyc();
        #1; chk("ill_trap", 32'(trap), 32'd1);
        chk("ill_cause", 32'(trap_cause), 32'd1);
        chk("ill_imem_req", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            imem_ack = 1'b1; dmem_ack = 1'b1;
            #1; chk("ill_ir_we", 32'(ir_we), 32'd0);
            chk("ill_pc_we", 32'(pc_we), 32'd0);
            chk("ill_sticky", 32'(trap), 32'd1);
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        rst_n = 1'b0;
        #1; chk("ill_rst_trap", 32'(trap), 32'd0);
        chk("ill_rst_cause", 32'(trap_cause), 32'd0);
        cyc();
        rst_n = 1'b1;

        // 5a: hold blocks fetch; then IMEM timeout after 16 waits
        hold_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; chk("hold_imem_req", 32'(imem_req), 32'd0); cyc();
        end
        for (int i = 0; i < 16; i++) begin
            hold_i = (i == 2);   // hold after request raised must not drop it
            #1; chk("to_imem_req", 32'(imem_req), 32'd1);
            chk("to_no_trap", 32'(trap), 32'd0); cyc();
        end
        hold_i = 1'b0;
        #1; chk("to_trap", 32'(trap), 32'd1);
        chk("to_cause", 32'(trap_cause), 32'd2);
        chk("to_imem_req_off", 32'(imem_req), 32'd0);

        // 5b: ack in the 16th request cycle wins
        do_reset();
        instr_i = I_ADD;
        for (int i = 0; i < 16; i++) begin
            imem_ack = (i == 15);
            #1; chk("late_imem_req", 32'(imem_req), 32'd1);
            chk("late_ir_we", 32'(ir_we), 32'(i == 15)); cyc();
        end
        imem_ack = 1'b0;
        #1; chk("late_no_trap", 32'(trap), 32'd0);

        // DMEM timeout on a load
        do_reset();
        fetch(I_LW); cyc(); cyc();
        for (int i = 0; i < 16; i++) begin
            #1; chk("dto_dmem_req", 32'(dmem_req), 32'd1);
            chk("dto_no_trap", 32'(trap), 32'd0); cyc();
        end
        #1; chk("dto_trap", 32'(trap), 32'd1);
        chk("dto_cause", 32'(trap_cause), 32'd3);
        chk("dto_dmem_req_off", 32'(dmem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
